uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver, the receiving end of the team's UART link.
- Runs on the system clock and consumes a one-cycle oversample tick (8x baud) from the baud generator's receive path.
- Finds the start bit, majority-votes mid-bit samples, assembles an LSB-first frame, and checks optional parity and the stop bit.
- Delivers each byte on a valid/ready handshake with per-frame error flags and a sticky overrun flag.

Parameters:
- DATA_BITS, 8, data bits per frame (legal 5..9).
- OVERSAMPLE, 8, rx_tick pulses per bit period (power of two, ≥8).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_tick  in  1  one-clk pulse at OVERSAMPLE x baud; all bit timing advances only on cycles with rx_tick=1.
- rxd  in  1  asynchronous serial line, idles high.
- rx_data  out  DATA_BITS  received word, bit 0 = first data bit on the line.
- rx_valid  out  1  rx_data and error flags are valid.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready.
- frame_err  out  1  stop bit sampled 0 for the presented word.
- parity_err  out  1  parity mismatch for the presented word (0 when PARITY_EN=0).
- overrun_err  out  1  sticky: a frame completed while the previous word was unaccepted.
- err_clr  in  1  single-cycle clear of overrun_err.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clk edge with reset=1):
  - Both synchronizer flops load 1; FSM enters IDLE; sample counter tc and bit counter load 0.
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun_err=0, busy=0.
  - Reset mid-frame aborts the frame; no rx_valid is produced.
- Synchronizer: rxd passes through 2 flops; rxs is the second flop output. All sampling uses rxs only.
- Sample counter tc (log2(OVERSAMPLE) bits) increments on each rx_tick in non-IDLE states and wraps to 0 after OVERSAMPLE-1.
- Majority vote:
  - M = OVERSAMPLE/2. Samples are taken at tc = M-1, M, M+1.
  - The bit value is the 2-of-3 majority, decided on the tick where tc = M+1 ("decision tick").
  - On the tick where tc = OVERSAMPLE-1 ("end tick") the FSM moves to the next bit.
- IDLE: on a tick with rxs=0, go to START with tc=1; the detecting tick counts as sample 0.
- START:
  - Decision = 1: false start (glitch); return to IDLE, no output.
  - Otherwise, on the end tick go to DATA with tc=0 and bitcnt=0.
- DATA:
  - On the decision tick, shift the voted bit in at the MSB of the DATA_BITS shift register, shifting right, so the result is LSB-first.
  - On the end tick: if bitcnt = DATA_BITS-1, go to PARITY (PARITY_EN=1) or STOP; else increment bitcnt.
- PARITY:
  - On the decision tick, capture the bit.
  - Expected parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
  - On the end tick, go to STOP.
- STOP:
  - On the decision tick, go to IDLE immediately. This is half a bit early, so the next start edge is not missed.
  - In the same cycle a completion event occurs.
- Completion event:
  - If rx_valid=1 and rx_ready=0 that cycle: set overrun_err; drop the new frame; rx_data and its flags stay unchanged.
  - Otherwise: load rx_data, frame_err = ~stop_vote, and parity_err; set rx_valid=1. Values are visible the clk cycle after the decision tick.
- Handshake:
  - rx_valid, rx_data and the flags stay stable until a cycle with rx_valid & rx_ready; rx_valid drops the next cycle.
  - If acceptance and completion fall in the same cycle, the new word loads and rx_valid stays 1. This is not an overrun.
- overrun_err is cleared only by err_clr or reset. If err_clr and a new overrun occur in the same cycle, set wins.
- Break (line held low):
  - Each frame completes with data 0 and frame_err=1.
  - The FSM then re-detects a start bit in IDLE on the next low tick.
- With rx_tick=0 permanently, the FSM holds its state and only the synchronizer and handshake logic operate.
- busy = (state != IDLE), registered with the state.

Test Plan:
- 8N1, OVERSAMPLE=8, rx_tick every 4 clk, send 0xA5 -> rx_data=0xA5, rx_valid=1, frame_err=0, parity_err=0; rx_valid held 20 cycles with rx_ready=0, drops the cycle after rx_ready=1.
- rxd low for 2 ticks then high -> busy pulses then returns 0 at the START decision tick; rx_valid never asserts.
- Frame 0x3C with the stop bit driven 0 -> rx_data=0x3C, frame_err=1; next frame 0x3C with a good stop bit -> frame_err=0.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 1 -> parity_err=0; resend with parity bit 0 -> parity_err=1.
- Back-to-back frames 0x11, 0x22 with rx_ready=0:
  - rx_data remains 0x11 and overrun_err=1.
  - err_clr pulse -> overrun_err=0; rx_ready=1 accepts 0x11.
  - A third frame 0x33 -> rx_data=0x33.
- Assert reset mid-DATA of frame 0x5A -> next cycle busy=0, rx_valid=0, all flags 0, rx_data=0; a subsequent full 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop sync, 2-of-3 mid-bit vote, LSB-first frame, optional parity, stop check.
// Word appears one clk after the stop-bit decision tick; held until rx_ready, a frame finishing while held sets overrun_err.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] TC_S0  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TC_S1  = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] TC_DEC = TCW'(OVERSAMPLE / 2 + 1);
  localparam logic [TCW-1:0] TC_END = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [TCW-1:0]       tc_q, tc_d;
  logic [BCW-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic rxs;
  logic vote;
  logic complete;
  logic par_exp;

  assign rxs  = sync2_q;
  // The third sample is the live one on the decision tick, so it never needs storing.
  assign vote = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign par_exp = (^shreg_q) ^ (PARITY_ODD != 0);

  always_comb begin
    sync1_d  = rxd;
    sync2_d  = sync1_q;
    state_d  = state_q;
    tc_d     = tc_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    par_d    = par_q;
    complete = 1'b0;

    if (rx_tick) begin
      if (state_q != S_IDLE) tc_d = tc_q + TCW'(1);
      if (tc_q == TC_S0) s0_d = rxs;
      if (tc_q == TC_S1) s1_d = rxs;

      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            tc_d    = TCW'(1);
          end
        end
        S_START: begin
          if (tc_q == TC_DEC && vote) begin
            state_d = S_IDLE;
            tc_d    = '0;
          end else if (tc_q == TC_END) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          if (tc_q == TC_DEC) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (tc_q == TC_END) begin
            if (bitcnt_q == BC_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            else bitcnt_d = bitcnt_q + BCW'(1);
          end
        end
        S_PARITY: begin
          if (tc_q == TC_DEC) par_d = vote;
          if (tc_q == TC_END) state_d = S_STOP;
        end
        S_STOP: begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          if (tc_q == TC_DEC) begin
            state_d  = S_IDLE;
            tc_d     = '0;
            complete = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tc_d    = '0;
        end
      endcase
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    busy_d       = (state_d != S_IDLE);

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (err_clr) overrun_d = 1'b0;

    if (complete) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d    = shreg_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = ~vote;
        parity_err_d = (PARITY_EN != 0) ? (par_q != par_exp) : 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      tc_q         <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      tc_q         <= tc_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule
